// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame builder: FSM encoding, word tags and
// the channel-word packing helper.
package adc_frame_pkg;

  localparam int ADC_DW   = 12;
  localparam int ADC_NS_W = 8;

  localparam logic [3:0] HDR_TAG_DEF = 4'hA;
  localparam logic [3:0] TRL_TAG_DEF = 4'hF;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HEADER  = 3'd1;
  localparam logic [2:0] S_WAIT_S  = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_TRAILER = 3'd4;

  // Channel word: channel index in the top nibble, raw sample below it.
  function automatic logic [15:0] pack_chan(input logic [3:0] idx,
                                            input logic [ADC_DW-1:0] sample);
    return {idx, sample};
  endfunction

endpackage

// File: rtl/adc_chan_scan.sv
// Finds the lowest set mask bit at or above a start point: either channel 0,
// or the channel after cur_idx.
module adc_chan_scan (
  input  logic [15:0] mask,
  input  logic [3:0]  cur_idx,
  input  logic        from_zero,
  output logic        found,
  output logic [3:0]  idx
);

  logic [4:0] first;

  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    first = from_zero ? 5'd0 : ({1'b0, cur_idx} + 5'd1);
    // Descending walk so the lowest qualifying bit is the one left standing.
    for (int i = 15; i >= 0; i--) begin
      if (mask[i] && (5'(i) >= first)) begin
        found = 1'b1;
        idx   = 4'(i);
      end
    end
  end

endmodule

// File: rtl/adc_frame_builder.sv
// Captures n_samples 16-channel sample sets on a trigger and streams them as
// header, masked channel words and trailer over a valid/ready interface.
module adc_frame_builder
  import adc_frame_pkg::*;
#(
  parameter int         DW      = ADC_DW,
  parameter int         NS_W    = ADC_NS_W,
  parameter logic [3:0] HDR_TAG = HDR_TAG_DEF,
  parameter logic [3:0] TRL_TAG = TRL_TAG_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [16*DW-1:0] ch_data,
  input  logic             sample_valid,
  input  logic             enable,
  input  logic             trig,
  input  logic [NS_W-1:0]  n_samples,
  input  logic [15:0]      ch_mask,
  output logic [15:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             overflow,
  output logic             trig_missed,
  output logic [11:0]      frame_cnt,
  output logic [2:0]       dbg_state
);

  // Handshake: a word transfers on a rising clk edge where out_valid and
  // out_ready are both high; until then out_valid stays up and out_data,
  // out_sof and out_eof hold, since they decode only from registered state.

  logic [2:0]       state;
  logic [NS_W-1:0]  n_lat;
  logic [NS_W-1:0]  sample_cnt;
  logic [15:0]      mask_lat;
  logic [3:0]       ch_idx;
  logic [16*DW-1:0] snap;
  logic [16*DW-1:0] pend;
  logic             pend_full;

  logic             accept;
  logic             cnt_done;
  logic [NS_W-1:0]  cnt_inc;
  logic             capture;
  logic             take;
  logic [16*DW-1:0] take_data;
  logic             scan_found;
  logic [3:0]       scan_idx;

  assign out_valid = (state == S_HEADER) || (state == S_SEND) || (state == S_TRAILER);
  assign out_sof   = (state == S_HEADER);
  assign out_eof   = (state == S_TRAILER);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  assign accept    = out_valid && out_ready;
  assign cnt_done  = (sample_cnt == n_lat);
  assign cnt_inc   = sample_cnt + 1'b1;
  assign capture   = sample_valid && !cnt_done;
  assign take      = pend_full || sample_valid;
  assign take_data = pend_full ? pend : ch_data;

  adc_chan_scan u_scan (
    .mask      (mask_lat),
    .cur_idx   (ch_idx),
    .from_zero (state != S_SEND),
    .found     (scan_found),
    .idx       (scan_idx)
  );

  always_comb begin
    out_data = 16'h0000;
    case (state)
      S_HEADER:  out_data = {HDR_TAG, frame_cnt};
      S_SEND:    out_data = pack_chan(ch_idx, snap[32'(ch_idx)*DW +: DW]);
      S_TRAILER: out_data = {TRL_TAG, 3'b000, overflow, sample_cnt[7:0]};
      default:   out_data = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      n_lat       <= '0;
      sample_cnt  <= '0;
      mask_lat    <= '0;
      ch_idx      <= '0;
      snap        <= '0;
      pend        <= '0;
      pend_full   <= 1'b0;
      overflow    <= 1'b0;
      trig_missed <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      trig_missed <= trig && (state != S_IDLE);

      case (state)
        S_IDLE: begin
          if (trig && enable) begin
            n_lat      <= n_samples;
            mask_lat   <= ch_mask;
            sample_cnt <= '0;
            overflow   <= 1'b0;
            pend_full  <= 1'b0;
            state      <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (accept) state <= (n_lat == '0) ? S_TRAILER : S_WAIT_S;
        end
        S_WAIT_S: begin
          if (take) begin
            if (scan_found) begin
              snap   <= take_data;
              ch_idx <= scan_idx;
              state  <= S_SEND;
            end else begin
              // Empty mask: the sample set is counted but produces no words.
              sample_cnt <= cnt_inc;
              if (cnt_inc == n_lat) state <= S_TRAILER;
            end
          end
        end
        S_SEND: begin
          if (accept) begin
            if (scan_found) begin
              ch_idx <= scan_idx;
            end else begin
              sample_cnt <= cnt_inc;
              state      <= (cnt_inc == n_lat) ? S_TRAILER : S_WAIT_S;
            end
          end
        end
        S_TRAILER: begin
          if (accept) begin
            frame_cnt <= frame_cnt + 12'd1;
            pend_full <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Pending buffer. In WAIT_S a full buffer is being drained into the
      // snapshot, so a sample arriving that same cycle refills it instead.
      if ((state == S_HEADER) || (state == S_SEND)) begin
        if (capture) begin
          if (!pend_full) begin
            pend      <= ch_data;
            pend_full <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end else if ((state == S_WAIT_S) && pend_full) begin
        if (capture) pend <= ch_data;
        else         pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_builder.sv
// Scenario bench for adc_frame_builder: expected stream words are queued when
// a frame is set up and compared as the DUT hands them over.
module tb_adc_frame_builder;

  localparam int DW = 12;

  logic             clk;
  logic             rst;
  logic [16*DW-1:0] ch_data;
  logic             sample_valid;
  logic             enable;
  logic             trig;
  logic [7:0]       n_samples;
  logic [15:0]      ch_mask;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sof;
  logic             out_eof;
  logic             busy;
  logic             overflow;
  logic             trig_missed;
  logic [11:0]      frame_cnt;
  logic [2:0]       dbg_state;

  int          checks;
  int          failures;
  logic [11:0] exp_fc;
  logic [17:0] exp_q[$];

  adc_frame_builder dut (
    .clk          (clk),
    .rst          (rst),
    .ch_data      (ch_data),
    .sample_valid (sample_valid),
    .enable       (enable),
    .trig         (trig),
    .n_samples    (n_samples),
    .ch_mask      (ch_mask),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_eof      (out_eof),
    .busy         (busy),
    .overflow     (overflow),
    .trig_missed  (trig_missed),
    .frame_cnt    (frame_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16*DW-1:0] rand_set();
    logic [16*DW-1:0] r;
    for (int c = 0; c < 16; c++) r[c*DW +: DW] = 12'($urandom_range(0, 4095));
    return r;
  endfunction

  // Queues a whole frame, triggers it, feeds n sample sets spaced so none is
  // lost, and compares every accepted word against the queue.
  task automatic run_frame(input logic [7:0] n, input logic [15:0] mask,
                           input logic [16*DW-1:0] base, input bit rand_data,
                           input int rmode, input bit mid_trig, output int missed);
    logic [16*DW-1:0] sets [16];
    logic [17:0]      exp_w;
    logic [17:0]      prev_w;
    logic             prev_stall;
    int               gap;
    int               cyc;
    gap    = 2 * $countones(mask) + 4;
    missed = 0;
    for (int k = 0; k < 16; k++) sets[k] = rand_data ? rand_set() : base;
    exp_q.push_back({2'b10, 4'hA, exp_fc});
    for (int k = 0; k < int'(n); k++)
      for (int c = 0; c < 16; c++)
        if (mask[c]) exp_q.push_back({2'b00, 4'(c), sets[k][c*DW +: DW]});
    exp_q.push_back({2'b01, 4'hF, 4'b0000, n});
    exp_fc = exp_fc + 12'd1;

    @(posedge clk); #1;
    trig = 1'b1; enable = 1'b1; n_samples = n; ch_mask = mask; out_ready = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    cyc = 0; prev_stall = 1'b0; prev_w = '0;
    fork
      begin
        for (int k = 0; k < int'(n); k++) begin
          ch_data = sets[k]; sample_valid = 1'b1;
          @(posedge clk); #1;
          sample_valid = 1'b0; ch_data = rand_set();
          repeat (gap - 1) begin @(posedge clk); #1; end
        end
      end
      begin
        while (exp_q.size() != 0 && cyc < 2000) begin
          @(negedge clk);
          if (trig_missed) missed++;
          if (prev_stall) begin
            checks++;
            if ({out_valid, out_sof, out_eof, out_data} !== {1'b1, prev_w}) begin
              failures++;
              $display("FAIL stall_hold: got valid=%b word=%h required valid=1 word=%h",
                       out_valid, {out_sof, out_eof, out_data}, prev_w);
            end
          end
          if (out_valid && out_ready) begin
            exp_w = exp_q.pop_front();
            checks++;
            if ({out_sof, out_eof, out_data} !== exp_w) begin
              failures++;
              $display("FAIL stream_word: got sof/eof/data=%h required %h",
                       {out_sof, out_eof, out_data}, exp_w);
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_w     = {out_sof, out_eof, out_data};
          @(posedge clk); #1;
          cyc++;
          case (rmode)
            1:       out_ready = ((cyc % 2) == 0);
            2:       out_ready = ((cyc % 3) != 2);
            default: out_ready = 1'b1;
          endcase
          trig = mid_trig && (cyc == 3);
        end
        checks++;
        if (exp_q.size() != 0) begin
          failures++;
          $display("FAIL frame_timeout: got %0d words still pending required 0", exp_q.size());
        end
        exp_q.delete();
      end
    join
    out_ready = 1'b1;
    trig = 1'b0;
    checks++;
    if (frame_cnt !== exp_fc) begin
      failures++;
      $display("FAIL frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
    checks++;
    if ({busy, overflow} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_frame: got busy=%b overflow=%b required 0 0", busy, overflow);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, out_sof, out_eof, busy, overflow, trig_missed} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {out_valid, out_sof, out_eof, busy, overflow, trig_missed});
    end
    checks++;
    if (out_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: got %h required 0000", out_data);
    end
    checks++;
    if (frame_cnt !== 12'd0) begin
      failures++;
      $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: got %0d required 0", dbg_state);
    end
  endtask

  task automatic test_basic();
    logic [16*DW-1:0] b;
    int m;
    b = '0;
    b[0 +: DW]    = 12'h123;
    b[2*DW +: DW] = 12'hABC;
    run_frame(8'd2, 16'h0005, b, 1'b0, 0, 1'b0, m);
    checks++;
    if (frame_cnt !== 12'd1) begin
      failures++;
      $display("FAIL basic_frame_cnt: got %0d required 1", frame_cnt);
    end
    checks++;
    if (m != 0) begin
      failures++;
      $display("FAIL basic_trig_missed: got %0d pulses required 0", m);
    end
  endtask

  task automatic test_backpressure();
    logic [16*DW-1:0] b;
    int m;
    b = '0;
    b[0 +: DW]    = 12'h123;
    b[2*DW +: DW] = 12'hABC;
    run_frame(8'd2, 16'h0005, b, 1'b0, 1, 1'b0, m);
    run_frame(8'd3, 16'($urandom_range(1, 65535)), '0, 1'b1, 2, 1'b0, m);
    run_frame(8'd2, 16'h8001, '0, 1'b1, 1, 1'b0, m);
  endtask

  task automatic test_overflow();
    logic [16*DW-1:0] sa, sd, se;
    logic [17:0]      exp_w;
    logic [11:0]      hdr_fc;
    int               cyc;
    sa = rand_set(); sd = rand_set(); se = rand_set();
    hdr_fc = exp_fc;
    exp_q.push_back({2'b10, 4'hA, hdr_fc});
    for (int c = 0; c < 16; c++) exp_q.push_back({2'b00, 4'(c), sa[c*DW +: DW]});
    for (int c = 0; c < 16; c++) exp_q.push_back({2'b00, 4'(c), sd[c*DW +: DW]});
    for (int c = 0; c < 16; c++) exp_q.push_back({2'b00, 4'(c), se[c*DW +: DW]});
    exp_q.push_back({2'b01, 4'hF, 4'b0001, 8'd3});
    exp_fc = exp_fc + 12'd1;

    @(posedge clk); #1;
    out_ready = 1'b0; trig = 1'b1; enable = 1'b1; n_samples = 8'd3; ch_mask = 16'hFFFF;
    @(posedge clk); #1;
    trig = 1'b0;
    // Three sets arrive while the header is stalled: the first is buffered.
    for (cyc = 0; cyc < 40; cyc++) begin
      sample_valid = (cyc == 2) || (cyc == 10) || (cyc == 20);
      ch_data = (cyc == 2) ? sa : rand_set();
      @(negedge clk);
      checks++;
      if ({out_valid, out_sof, out_data} !== {2'b11, 4'hA, hdr_fc}) begin
        failures++;
        $display("FAIL hold_header: got valid=%b sof=%b data=%h required 1 1 %h",
                 out_valid, out_sof, out_data, {4'hA, hdr_fc});
      end
      @(posedge clk); #1;
    end
    sample_valid = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: got %b required 1", overflow);
    end
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        exp_w = exp_q.pop_front();
        checks++;
        if ({out_sof, out_eof, out_data} !== exp_w) begin
          failures++;
          $display("FAIL overflow_word: got %h required %h", {out_sof, out_eof, out_data}, exp_w);
        end
      end
      @(posedge clk); #1;
      cyc++;
      sample_valid = (cyc == 25) || (cyc == 60);
      ch_data = (cyc == 25) ? sd : se;
    end
    sample_valid = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL overflow_timeout: got %0d words pending required 0", exp_q.size());
    end
    exp_q.delete();
    checks++;
    if ({busy, overflow} !== 2'b01) begin
      failures++;
      $display("FAIL overflow_hold: got busy=%b overflow=%b required 0 1", busy, overflow);
    end
    checks++;
    if (frame_cnt !== exp_fc) begin
      failures++;
      $display("FAIL overflow_frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

  task automatic test_zero_cases();
    int m;
    run_frame(8'd0, 16'hFFFF, '0, 1'b1, 0, 1'b0, m);
    run_frame(8'd4, 16'h0000, '0, 1'b1, 0, 1'b0, m);
    run_frame(8'd0, 16'h0000, '0, 1'b1, 1, 1'b0, m);
  endtask

  task automatic test_trig_while_busy();
    logic [16*DW-1:0] b;
    int m;
    int seen;
    b = rand_set();
    run_frame(8'd2, 16'h0005, b, 1'b0, 0, 1'b1, m);
    checks++;
    if (m != 1) begin
      failures++;
      $display("FAIL trig_missed_pulse: got %0d pulses required 1", m);
    end
    @(posedge clk); #1;
    enable = 1'b0; trig = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL enable_low: got %0d active cycles required 0", seen);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    int cyc;
    int m;
    @(posedge clk); #1;
    trig = 1'b1; enable = 1'b1; n_samples = 8'd1; ch_mask = 16'h0003; out_ready = 1'b1;
    @(posedge clk); #1;
    trig = 1'b0; ch_data = rand_set(); sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    hit = 1'b0; cyc = 0;
    while (!hit && cyc < 20) begin
      if (dbg_state == 3'd3) hit = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    checks++;
    if (!hit || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reach_send: got state=%0d valid=%b required 3 1", dbg_state, out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_sof, out_eof, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset: got valid/sof/eof/busy=%b required 0000",
               {out_valid, out_sof, out_eof, busy});
    end
    checks++;
    if (frame_cnt !== 12'd0) begin
      failures++;
      $display("FAIL reset_clears_cnt: got %0d required 0", frame_cnt);
    end
    exp_fc = 12'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(8'd1, 16'h0003, '0, 1'b1, 0, 1'b0, m);
  endtask

  task automatic test_frame_cnt_wrap();
    int m;
    while (exp_fc != 12'hFFF) run_frame(8'd0, 16'($urandom), '0, 1'b0, 0, 1'b0, m);
    checks++;
    if (frame_cnt !== 12'hFFF) begin
      failures++;
      $display("FAIL pre_wrap: got %h required fff", frame_cnt);
    end
    run_frame(8'd1, 16'h0010, '0, 1'b1, 0, 1'b0, m);
    checks++;
    if (frame_cnt !== 12'h000) begin
      failures++;
      $display("FAIL wrap: got %h required 000", frame_cnt);
    end
    run_frame(8'd0, 16'h0001, '0, 1'b0, 0, 1'b0, m);
  endtask

  initial begin
    checks = 0; failures = 0; exp_fc = 12'd0;
    rst = 1'b1; ch_data = '0; sample_valid = 1'b0; enable = 1'b0; trig = 1'b0;
    n_samples = 8'd0; ch_mask = 16'h0000; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_basic();
    test_backpressure();
    test_overflow();
    test_zero_cases();
    test_trig_while_busy();
    test_reset_mid_frame();
    test_frame_cnt_wrap();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
